// File: rtl/mem_access_unit_if.sv
// Requester and data-memory signal bundle for mem_access_unit.
// slave = the access unit, master = the execute stage plus the memory model.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       write_data;
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a 64-bit-port byte memory; sub-doubleword stores are read-modify-write.
// Optional MEM_ALIGN_CHECK_EN rejects accesses not aligned to their size, like a range error.
module mem_access_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            r_state;
  logic              r_write;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [63:0]       r_wdata;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [63:0]       r_resp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [63:0]       r_write_data;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_reject;
  logic [63:0]       w_ext;
  logic [63:0]       w_merge;

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  always_comb begin
    case (bus.req_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = bus.req_addr[0];
      2'd2:    w_misalign = |bus.req_addr[1:0];
      default: w_misalign = |bus.req_addr[2:0];
    endcase
  end
  assign w_reject = (bus.req_addr > ADDR_W'(MEM_BYTES - 8)) || w_misalign;
`else
  assign w_reject = (bus.req_addr > ADDR_W'(MEM_BYTES - 8));
`endif

  // Load extension and store merge both work on the doubleword present during READ.
  always_comb begin
    w_ext   = bus.read_data;
    w_merge = r_wdata;
    case (r_size)
      2'd0: begin
        w_ext   = r_uns ? {56'd0, bus.read_data[7:0]} : {{56{bus.read_data[7]}}, bus.read_data[7:0]};
        w_merge = {bus.read_data[63:8], r_wdata[7:0]};
      end
      2'd1: begin
        w_ext   = r_uns ? {48'd0, bus.read_data[15:0]} : {{48{bus.read_data[15]}}, bus.read_data[15:0]};
        w_merge = {bus.read_data[63:16], r_wdata[15:0]};
      end
      2'd2: begin
        w_ext   = r_uns ? {32'd0, bus.read_data[31:0]} : {{32{bus.read_data[31]}}, bus.read_data[31:0]};
        w_merge = {bus.read_data[63:32], r_wdata[31:0]};
      end
      default: begin
        w_ext   = bus.read_data;
        w_merge = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'd0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_write_data <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_uns       <= bus.req_unsigned;
            r_size      <= bus.req_size;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (w_reject) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_mem_addr <= bus.req_addr;
              if (bus.req_write && (bus.req_size == 2'd3)) begin
                r_state      <= WRITE;
                r_mem_write  <= 1'b1;
                r_write_data <= bus.req_wdata;
              end else begin
                r_state    <= READ;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        READ: begin
          r_mem_read <= 1'b0;
          if (r_write) begin
            r_state      <= WRITE;
            r_mem_write  <= 1'b1;
            r_write_data <= w_merge;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_ext;
          end
        end
        WRITE: begin
          r_mem_write  <= 1'b0;
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.write_data = r_write_data;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array reference model.
// The environment memory commits on negedge and returns read data combinationally.
module tb_mem_access_unit;
  localparam int MEM_BYTES = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(64)) bus ();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        mem_init_done = 1'b0;
  logic [63:0] rd_word;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt, wr_cnt, both_cnt, addr_bad, vld_cnt;
  logic [63:0] exp_addr;

  // Environment memory: random fill with fixed test-plan bytes on the first negedge.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
      mem[2] = 8'h01; mem[3] = 8'h02; mem[4] = 8'h03; mem[5] = 8'h84;
      mem[8] = 8'h08; mem[9] = 8'h00; mem[10] = 8'h10;
      for (int i = 11; i < 16; i++) mem[i] = 8'h00;
      mem[20] = 8'h80;
      for (int i = 0; i < 8; i++) mem[24+i] = 8'(8'h88 - 8'h11 * i);
      mem_init_done = 1'b1;
    end else if (bus.mem_write) begin
      for (int i = 0; i < 8; i++)
        if (bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
          mem[int'(bus.mem_addr[6:0]) + i] = bus.write_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++)
      if (bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
        rd_word[8*i +: 8] = mem[int'(bus.mem_addr[6:0]) + i];
  end
  assign bus.read_data = rd_word;

  always @(negedge clk) begin
    rd_cnt  += int'(bus.mem_read);
    wr_cnt  += int'(bus.mem_write);
    vld_cnt += int'(bus.resp_valid);
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if ((bus.mem_read || bus.mem_write) && bus.mem_addr != exp_addr) addr_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [63:0] a, input logic [1:0] sz);
    logic e;
    e = a > 64'(MEM_BYTES - 8);
`ifdef MEM_ALIGN_CHECK_EN
    if (a % (64'd1 << sz) != 0) e = 1'b1;
`else
    if (sz == 2'd3 && a == 64'hFFFF_FFFF_FFFF_FFFF) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [63:0] ref_load(input int a, input int sz, input logic u);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a+i];
    if (!u && nb < 8 && v[8*nb-1])
      for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input int a, input int sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = wd[8*i +: 8];
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd, output logic [63:0] got);
    logic [63:0] exp_d;
    logic        exp_e, found;
    int          exp_lat, exp_rd, exp_wr, n;
    exp_e = model_err(a, sz);
    if (exp_e) begin
      exp_d = '0; exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!w) begin
      exp_d = ref_load(int'(a), int'(sz), u); exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end else begin
      exp_d = '0; exp_lat = (sz == 2'd3) ? 2 : 3; exp_rd = (sz == 2'd3) ? 0 : 1; exp_wr = 1;
      ref_store(int'(a), int'(sz), wd);
    end
    @(negedge clk);
    chk("idle_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_no_resp", 64'(bus.resp_valid), 64'd0);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; addr_bad = 0; exp_addr = a;
    // Junk on the request lines while busy must be ignored.
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_addr = 64'($urandom_range(0, 80)); bus.req_wdata = {32'($urandom), 32'($urandom)};
    found = 1'b0; n = 0;
    while (!found && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) found = 1'b1;
    end
    bus.req_valid = 1'b0;
    if (!found) n = 99;
    got = bus.resp_rdata;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("resp_err", 64'(bus.resp_err), 64'(exp_e));
    chk("resp_rdata", bus.resp_rdata, exp_d);
    chk("mem_read_cycles", 64'(rd_cnt), 64'(exp_rd));
    chk("mem_write_cycles", 64'(wr_cnt), 64'(exp_wr));
    chk("strobe_overlap", 64'(both_cnt), 64'd0);
    chk("strobe_addr", 64'(addr_bad), 64'd0);
  endtask

  task automatic mem_cmp(input string tag);
    logic [63:0] dg, de;
    for (int d = 0; d < MEM_BYTES / 8; d++) begin
      for (int i = 0; i < 8; i++) begin
        dg[8*i +: 8] = mem[8*d+i];
        de[8*i +: 8] = ref_mem[8*d+i];
      end
      chk(tag, dg, de);
    end
  endtask

  initial begin : main
    logic [63:0] got, a;
    logic [1:0]  sz;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; addr_bad = 0; vld_cnt = 0; exp_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_write_data", bus.write_data, 64'd0);
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = mem[i];
    reset = 1'b0;

    do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, got);
    chk("ld_d8", got, 64'h0000_0000_0010_0008);
    do_req(1'b0, 2'd0, 1'b0, 64'd20, 64'd0, got);
    chk("ld_b20_s", got, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 64'd20, 64'd0, got);
    chk("ld_b20_u", got, 64'h0000_0000_0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 64'd2, 64'd0, got);
`ifdef MEM_ALIGN_CHECK_EN
    chk("ld_w2", got, 64'd0);
`else
    chk("ld_w2", got, 64'hFFFF_FFFF_8403_0201);
`endif
    do_req(1'b1, 2'd1, 1'b0, 64'd24, 64'hDEAD_CAFE_1234_BEEF, got);
    do_req(1'b0, 2'd3, 1'b0, 64'd24, 64'd0, got);
    chk("ld_d24_merged", got, 64'h1122_3344_5566_BEEF);
    do_req(1'b0, 2'd3, 1'b0, 64'd56, 64'd0, got);
    do_req(1'b0, 2'd0, 1'b0, 64'd57, 64'd0, got);
    chk("ld_b57_data", got, 64'd0);
    do_req(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, got);

    // Reset during READ of a byte store: nothing commits, no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_addr = 64'd0; bus.req_wdata = ~{56'd0, ref_mem[0]};
    @(posedge clk); #1;
    bus.req_valid = 1'b0; reset = 1'b1; wr_cnt = 0; vld_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_read", 64'(bus.mem_read), 64'd0);
    repeat (5) @(negedge clk);
    chk("rst_mid_writes", 64'(wr_cnt), 64'd0);
    chk("rst_mid_resps", 64'(vld_cnt), 64'd0);
    mem_cmp("rst_mid_mem");

    // Reset and a valid request on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd3;
    bus.req_addr = 64'd0; bus.req_wdata = 64'h0123_4567_89AB_CDEF;
    wr_cnt = 0; vld_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0; bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_req_ready2", 64'(bus.req_ready), 64'd1);
    chk("rst_req_writes", 64'(wr_cnt), 64'd0);
    chk("rst_req_resps", 64'(vld_cnt), 64'd0);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 71));
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
      if ($urandom_range(0, 15) == 0) a = {32'($urandom), 32'($urandom)};
      do_req(1'($urandom), sz, 1'($urandom), a, {32'($urandom), 32'($urandom)}, got);
    end
    mem_cmp("final_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
